// File: rtl/presc_pkg.sv
// Shared types and constants for the square-wave prescaler controller.
//   state_e : controller states (IDLE, RUN, DRAIN)
//   cfg_t   : one period/high-time configuration word, sized for DFLT_CNT_W
//   DFLT_*  : default widths and the power-on period/high time (60 Hz at 50 MHz)
package presc_pkg;

  localparam int DFLT_CNT_W   = 20;
  localparam int DFLT_BURST_W = 8;
  localparam int DFLT_PERIOD  = 833334;
  localparam int DFLT_HIGH    = 416667;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  typedef struct packed {
    logic [DFLT_CNT_W-1:0] period;
    logic [DFLT_CNT_W-1:0] high;
  } cfg_t;

endpackage

// File: rtl/presc_core.sv
// Prescaler datapath: period counter, duty compare and wrap tick.
//   i_Clk, i_Rst_n : clock, asynchronous active-low reset
//   i_En           : counter runs (controller is in RUN or DRAIN)
//   i_Clr          : controller leaves the running states this cycle
//   i_Period       : active period in clocks
//   i_High         : active high time in clocks
//   o_Wrap         : combinational, counter is on its last count this cycle
//   o_Presc        : registered wave, high when cnt >= Period-High
//   o_Tick         : registered one-cycle pulse per wrap
module presc_core #(
  parameter int CNT_W = 20
) (
  input  logic             i_Clk,
  input  logic             i_Rst_n,
  input  logic             i_En,
  input  logic             i_Clr,
  input  logic [CNT_W-1:0] i_Period,
  input  logic [CNT_W-1:0] i_High,
  output logic             o_Wrap,
  output logic             o_Presc,
  output logic             o_Tick
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] thresh;
  logic             presc_q, presc_d;
  logic             tick_q, tick_d;

  assign thresh = i_Period - i_High;
  assign o_Wrap = i_En && (cnt_q == i_Period - CNT_W'(1));

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path holds
    // an old value and no latch is inferred.
    cnt_d = cnt_q + CNT_W'(1);
    if (!i_En || i_Clr || o_Wrap) begin
      cnt_d = '0;
    end
    // The wave is dropped on the edge the controller goes idle, so it is
    // already low in the first idle cycle.
    presc_d = i_En && !i_Clr && (cnt_q >= thresh);
    // The final wrap of a burst or drain still produces its tick.
    tick_d  = o_Wrap;
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      cnt_q   <= '0;
      presc_q <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      cnt_q   <= cnt_d;
      presc_q <= presc_d;
      tick_q  <= tick_d;
    end
  end

  assign o_Presc = presc_q;
  assign o_Tick  = tick_q;

endmodule

// File: rtl/presc_ctrl.sv
// Run-time controller for the shared square-wave prescaler.
// Double-buffers period/high configuration (shadow -> active on wrap), and
// sequences start, stop and burst (N-period) operation around presc_core.
//   i_Clk, i_Rst_n            : clock, asynchronous active-low reset
//   i_Cfg_Valid / o_Cfg_Ready : config handshake, Ready = shadow empty
//   i_Cfg_Period, i_Cfg_High  : offered configuration
//   o_Cfg_Err                 : one-cycle pulse, offered config rejected
//   i_Start, i_Stop           : run control, level sampled every cycle
//   i_Mode, i_Burst           : 0 free-run / 1 burst, burst period count
//   o_Presc, o_Tick           : prescaled wave, wrap tick
//   o_Busy, o_Done            : running (RUN/DRAIN), completion pulse
// Build option: PRESC_CTRL_IMM_STOP_EN makes Stop end the run at once
// (pending shadow loads, o_Done pulses) and removes the DRAIN state.
module presc_ctrl
  import presc_pkg::*;
#(
  parameter int CNT_W      = DFLT_CNT_W,
  parameter int DEF_PERIOD = DFLT_PERIOD,
  parameter int DEF_HIGH   = DFLT_HIGH,
  parameter int BURST_W    = DFLT_BURST_W
) (
  input  logic               i_Clk,
  input  logic               i_Rst_n,
  input  logic               i_Cfg_Valid,
  output logic               o_Cfg_Ready,
  input  logic [CNT_W-1:0]   i_Cfg_Period,
  input  logic [CNT_W-1:0]   i_Cfg_High,
  output logic               o_Cfg_Err,
  input  logic               i_Start,
  input  logic               i_Stop,
  input  logic               i_Mode,
  input  logic [BURST_W-1:0] i_Burst,
  output logic               o_Presc,
  output logic               o_Tick,
  output logic               o_Busy,
  output logic               o_Done
);

  localparam cfg_t RST_CFG = '{period: DFLT_CNT_W'(DEF_PERIOD), high: DFLT_CNT_W'(DEF_HIGH)};

  state_e             state_q, state_d;
  cfg_t               act_q, act_d;
  cfg_t               shd_q, shd_d;
  cfg_t               cfg_in;
  logic               shd_full_q, shd_full_d;
  logic [BURST_W-1:0] rem_q, rem_d;
  logic               mode_q, mode_d;
  logic               err_q, err_d;
  logic               done_q, done_d;
  logic               wrap;
  logic               cfg_ok;
  logic               accept;
  logic               last_burst;

  assign cfg_in     = '{period: i_Cfg_Period, high: i_Cfg_High};
  assign cfg_ok     = (cfg_in.period >= DFLT_CNT_W'(2)) && (cfg_in.high != '0) &&
                      (cfg_in.high < cfg_in.period);
  assign accept     = i_Cfg_Valid && !shd_full_q;
  assign last_burst = mode_q && (rem_q == BURST_W'(1));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (i_Start && !i_Stop) state_d = ST_RUN;
      end
      ST_RUN: begin
`ifdef PRESC_CTRL_IMM_STOP_EN
        if (i_Stop || (wrap && last_burst)) state_d = ST_IDLE;
`else
        // A stop on the wrap cycle has nothing left to drain.
        if (wrap && (last_burst || i_Stop)) state_d = ST_IDLE;
        else if (i_Stop)                    state_d = ST_DRAIN;
`endif
      end
`ifndef PRESC_CTRL_IMM_STOP_EN
      ST_DRAIN: begin
        if (wrap) state_d = ST_IDLE;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    act_d      = act_q;
    shd_d      = shd_q;
    shd_full_d = shd_full_q;
    err_d      = 1'b0;
    rem_d      = rem_q;
    mode_d     = mode_q;
    done_d     = (state_q != ST_IDLE) && (state_d == ST_IDLE);

    // Active config only changes between periods: at a wrap, or when the
    // run ends (which also covers an immediate stop).
    if (shd_full_q && (wrap || state_d == ST_IDLE)) begin
      act_d      = shd_q;
      shd_full_d = 1'b0;
    end

    // accept implies the shadow is empty, so this never collides with the
    // shadow transfer above.
    if (accept) begin
      if (!cfg_ok) begin
        err_d = 1'b1;
      end else if (state_q == ST_IDLE || state_d == ST_IDLE) begin
        act_d = cfg_in;
      end else begin
        shd_d      = cfg_in;
        shd_full_d = 1'b1;
      end
    end

    if (state_q == ST_IDLE && state_d == ST_RUN) begin
      mode_d = i_Mode;
      rem_d  = (i_Burst == '0) ? BURST_W'(1) : i_Burst;
    end else if (state_q == ST_RUN && wrap && mode_q) begin
      rem_d = rem_q - BURST_W'(1);
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q    <= ST_IDLE;
      act_q      <= RST_CFG;
      shd_q      <= RST_CFG;
      shd_full_q <= 1'b0;
      rem_q      <= '0;
      mode_q     <= 1'b0;
      err_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      act_q      <= act_d;
      shd_q      <= shd_d;
      shd_full_q <= shd_full_d;
      rem_q      <= rem_d;
      mode_q     <= mode_d;
      err_q      <= err_d;
      done_q     <= done_d;
    end
  end

  presc_core #(
    .CNT_W (CNT_W)
  ) u_core (
    .i_Clk    (i_Clk),
    .i_Rst_n  (i_Rst_n),
    .i_En     (state_q != ST_IDLE),
    .i_Clr    (state_d == ST_IDLE),
    .i_Period (act_q.period),
    .i_High   (act_q.high),
    .o_Wrap   (wrap),
    .o_Presc  (o_Presc),
    .o_Tick   (o_Tick)
  );

  assign o_Cfg_Ready = !shd_full_q;
  assign o_Cfg_Err   = err_q;
  assign o_Busy      = (state_q != ST_IDLE);
  assign o_Done      = done_q;

endmodule

// File: tb/tb_presc_ctrl.sv
// Directed bench for presc_ctrl. Each step pushes the expected per-cycle
// outputs onto a scoreboard queue; the queue is then drained one clock per
// entry, comparing #1 after each rising edge. Default config is overridden to
// 12/5 so the post-reset waveform fits in a short run.
module tb_presc_ctrl;

  localparam int CNT_W   = 20;
  localparam int BURST_W = 8;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               cfg_valid;
  logic               cfg_ready;
  logic [CNT_W-1:0]   cfg_period;
  logic [CNT_W-1:0]   cfg_high;
  logic               cfg_err;
  logic               start;
  logic               stop;
  logic               mode;
  logic [BURST_W-1:0] burst;
  logic               presc;
  logic               tick;
  logic               busy;
  logic               done;

  presc_ctrl #(
    .CNT_W      (CNT_W),
    .DEF_PERIOD (12),
    .DEF_HIGH   (5),
    .BURST_W    (BURST_W)
  ) dut (
    .i_Clk        (clk),
    .i_Rst_n      (rst_n),
    .i_Cfg_Valid  (cfg_valid),
    .o_Cfg_Ready  (cfg_ready),
    .i_Cfg_Period (cfg_period),
    .i_Cfg_High   (cfg_high),
    .o_Cfg_Err    (cfg_err),
    .i_Start      (start),
    .i_Stop       (stop),
    .i_Mode       (mode),
    .i_Burst      (burst),
    .o_Presc      (presc),
    .o_Tick       (tick),
    .o_Busy       (busy),
    .o_Done       (done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic presc;
    logic tick;
    logic busy;
    logic done;
    logic ready;
    logic err;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  task automatic check(input string tag, input logic obs, input logic expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s cycle=%0d observed=%b expected=%b", tag, cyc, obs, expv);
    end
  endtask

  function automatic void push(input logic p, input logic t, input logic b,
                               input logic d, input logic r, input logic e);
    exp_t x;
    x.presc = p; x.tick = t; x.busy = b; x.done = d; x.ready = r; x.err = e;
    sb.push_back(x);
  endfunction

  // One entry per cycle following a running cycle with count c.
  function automatic void push_cnt(input int p, input int h, input int c0,
                                   input int c1, input logic rdy, input logic err = 1'b0);
    for (int c = c0; c <= c1; c++) push(c >= p - h, c == p - 1, 1'b1, 1'b0, rdy, err);
  endfunction

  function automatic void push_end(input logic t);
    push(1'b0, t, 1'b0, 1'b1, 1'b1, 1'b0);
  endfunction

  function automatic void push_idle(input int n);
    for (int i = 0; i < n; i++) push(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
  endfunction

  function automatic void push_start();
    push(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
  endfunction

  task automatic run_all();
    exp_t e;
    while (sb.size() > 0) begin
      @(posedge clk);
      #1;
      cyc++;
      e = sb.pop_front();
      check("presc", presc,     e.presc);
      check("tick",  tick,      e.tick);
      check("busy",  busy,      e.busy);
      check("done",  done,      e.done);
      check("ready", cfg_ready, e.ready);
      check("err",   cfg_err,   e.err);
    end
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_presc"}, presc,     1'b0);
    check({pfx, "_tick"},  tick,      1'b0);
    check({pfx, "_busy"},  busy,      1'b0);
    check({pfx, "_done"},  done,      1'b0);
    check({pfx, "_err"},   cfg_err,   1'b0);
    check({pfx, "_ready"}, cfg_ready, 1'b1);
  endtask

  task automatic offer(input int p, input int h);
    cfg_valid  = 1'b1;
    cfg_period = CNT_W'(p);
    cfg_high   = CNT_W'(h);
  endtask

  initial begin
    rst_n = 1'b1; cfg_valid = 1'b0; cfg_period = '0; cfg_high = '0;
    start = 1'b0; stop = 1'b0; mode = 1'b0; burst = '0;
    #1 rst_n = 1'b0;
    #11;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Load 10/4 while idle, free-run three periods.
    offer(10, 4); push_idle(1); run_all(); cfg_valid = 1'b0;
    start = 1'b1; mode = 1'b0; push_start(); run_all(); start = 1'b0;
    for (int k = 0; k < 3; k++) push_cnt(10, 4, 0, 9, 1'b1);
    run_all();

    // Mid-period 6/3 goes to shadow; a second offer (7/2) stalls until wrap.
    push_cnt(10, 4, 0, 1, 1'b1); run_all();
    offer(6, 3); push_cnt(10, 4, 2, 2, 1'b0); run_all();
    offer(7, 2); push_cnt(10, 4, 3, 8, 1'b0); push_cnt(10, 4, 9, 9, 1'b1); run_all();
    push_cnt(6, 3, 0, 0, 1'b0); run_all(); cfg_valid = 1'b0;
    push_cnt(6, 3, 1, 4, 1'b0); push_cnt(6, 3, 5, 5, 1'b1); push_cnt(7, 2, 0, 6, 1'b1);
    run_all();

    // Invalid offers are consumed, flagged, and leave the wave alone.
    offer(5, 5); push_cnt(7, 2, 0, 0, 1'b1, 1'b1); run_all();
    offer(1, 0); push_cnt(7, 2, 1, 1, 1'b1, 1'b1); run_all(); cfg_valid = 1'b0;
    push_cnt(7, 2, 2, 6, 1'b1); push_cnt(7, 2, 0, 6, 1'b1); run_all();

    // Stop at count 0 of 7/2.
    stop = 1'b1;
`ifdef PRESC_CTRL_IMM_STOP_EN
    push_end(1'b0); run_all(); stop = 1'b0;
`else
    push_cnt(7, 2, 0, 0, 1'b1); run_all(); stop = 1'b0;
    push_cnt(7, 2, 1, 5, 1'b1); push_end(1'b1);
`endif
    push_idle(1); run_all();

    // Burst of 3 at 8/2, then burst 0 runs a single period.
    offer(8, 2); push_idle(1); run_all(); cfg_valid = 1'b0;
    start = 1'b1; mode = 1'b1; burst = 8'd3; push_start(); run_all();
    start = 1'b0; mode = 1'b0; burst = '0;
    push_cnt(8, 2, 0, 7, 1'b1); push_cnt(8, 2, 0, 7, 1'b1); push_cnt(8, 2, 0, 6, 1'b1);
    push_end(1'b1); push_idle(2); run_all();
    start = 1'b1; mode = 1'b1; burst = '0; push_start(); run_all();
    start = 1'b0; mode = 1'b0;
    push_cnt(8, 2, 0, 6, 1'b1); push_end(1'b1); push_idle(1); run_all();

    // Stop at count 3 of 10/4.
    offer(10, 4); push_idle(1); run_all(); cfg_valid = 1'b0;
    start = 1'b1; push_start(); run_all(); start = 1'b0;
    push_cnt(10, 4, 0, 2, 1'b1); run_all();
    stop = 1'b1;
`ifdef PRESC_CTRL_IMM_STOP_EN
    push_end(1'b0); run_all(); stop = 1'b0;
`else
    push_cnt(10, 4, 3, 3, 1'b1); run_all(); stop = 1'b0;
    push_cnt(10, 4, 4, 8, 1'b1); push_end(1'b1);
`endif
    push_idle(1); run_all();

    // Start and Stop together in idle: no run.
    start = 1'b1; stop = 1'b1; push_idle(2); run_all();
    start = 1'b0; stop = 1'b0; push_idle(1); run_all();

    // Reset mid-period with a shadow pending, then restart on the defaults.
    start = 1'b1; push_start(); run_all(); start = 1'b0;
    push_cnt(10, 4, 0, 4, 1'b1); run_all();
    offer(6, 3); push_cnt(10, 4, 5, 5, 1'b0); run_all(); cfg_valid = 1'b0;
    push_cnt(10, 4, 6, 6, 1'b0); run_all();
    rst_n = 1'b0;
    #2;
    check_reset_outputs("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    start = 1'b1; push_start(); run_all(); start = 1'b0;
    push_cnt(12, 5, 0, 11, 1'b1); push_cnt(12, 5, 0, 11, 1'b1); run_all();
    stop = 1'b1;
`ifdef PRESC_CTRL_IMM_STOP_EN
    push_end(1'b0); run_all(); stop = 1'b0;
`else
    push_cnt(12, 5, 0, 0, 1'b1); run_all(); stop = 1'b0;
    push_cnt(12, 5, 1, 10, 1'b1); push_end(1'b1);
`endif
    push_idle(1); run_all();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
